// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DW = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  // Bits needed to index v items; never less than 1 so ports stay legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational circular first-set search starting at ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the last hit is the one closest to ptr.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N requesters.
// Optional LAUNCH timeout with err pulses when UART_ARB_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a request while the transmitter is not busy
// LAUNCH    | tx_send held with latched character until busy rises
// WAIT_DONE | frame in progress, waiting for busy to fall
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = UART_DW,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*DW-1:0]     req_data,
  input  logic [N-1:0]        req_ps,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        done,
  output logic [clog2(N)-1:0] grant_id,
  output logic                tx_send,
  output logic [DW-1:0]       tx_din,
  output logic                tx_ps,
  input  logic                tx_busy
`ifdef UART_ARB_TIMEOUT_EN
  ,output logic [N-1:0]       err
`endif
);

  localparam int IW = clog2(N);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          send_q, send_d;
  logic [DW-1:0] din_q, din_d;
  logic          ps_q, ps_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  done_q, done_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  err_q, err_d;
`endif

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Explicit compare keeps the wrap correct for non-power-of-2 N.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    return (int'(g) == N - 1) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    send_d  = send_q;
    din_d   = din_q;
    ps_d    = ps_q;
    ack_d   = '0;
    done_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid && !tx_busy) begin
          gid_d   = pick_idx;
          din_d   = req_data[int'(pick_idx)*DW +: DW];
          ps_d    = req_ps[pick_idx];
          send_d  = 1'b1;
          state_d = LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = CW'(TIMEOUT - 1);
`endif
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          send_d        = 1'b0;
          ack_d[gid_q]  = 1'b1;
          state_d       = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == '0) begin
          send_d        = 1'b0;
          err_d[gid_q]  = 1'b1;
          ptr_d         = next_ptr(gid_q);
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d[gid_q] = 1'b1;
          ptr_d         = next_ptr(gid_q);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      send_q  <= 1'b0;
      din_q   <= '0;
      ps_q    <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      send_q  <= send_d;
      din_q   <= din_d;
      ps_q    <= ps_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign grant_id = gid_q;
  assign tx_send  = send_q;
  assign tx_din   = din_q;
  assign tx_ps    = ps_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err      = err_q;
`endif

endmodule
